// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequences one instruction at a time through an external
// combinational ALU, using an internal 8x16 register file, and returns a
// response over a valid/ready port.
module alu_issue_ctrl #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned REG_CNT = 8,
    parameter int unsigned SHAMT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [15:0]          instr,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_addr,
    input  logic [DATA_W-1:0]    cfg_wdata,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [2:0]           alu_sel,
    output logic [SHAMT_W-1:0]   alu_shamt,
    input  logic [DATA_W-1:0]    alu_result,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [DATA_W-1:0]    res_data,
    output logic [2:0]           res_rd,
    output logic                 res_err,
    output logic [15:0]          op_count
);

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned CNT_W  = 16;
    localparam logic [OP_W-1:0] OP_ILLEGAL = OP_W'(7);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CAPT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   rf [REG_CNT];
    logic [OP_W-1:0]     op_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [ADDR_W-1:0]   rs_q;
    logic [ADDR_W-1:0]   rt_q;
    logic [SHAMT_W-1:0]  sh_q;
    logic [DATA_W-1:0]   rs_val;
    logic [DATA_W-1:0]   rt_val;

    // r0 always reads as zero regardless of storage contents
    assign rs_val = (rs_q == '0) ? '0 : rf[rs_q];
    assign rt_val = (rt_q == '0) ? '0 : rf[rt_q];

    // Preload writes take priority over instruction acceptance in IDLE
    assign instr_ready = rst_n & (state == S_IDLE) & ~cfg_we;

    // Sequencer: accept, drive ALU, capture/write back, hold response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            sh_q      <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            alu_shamt <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
            res_err   <= 1'b0;
            op_count  <= '0;
            for (int i = 0; i < int'(REG_CNT); i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_we) begin
                        if (cfg_addr != '0) begin
                            rf[cfg_addr] <= cfg_wdata;
                        end
                    end else if (instr_valid) begin
                        op_q  <= instr[15:13];
                        rd_q  <= instr[12:10];
                        rs_q  <= instr[9:7];
                        rt_q  <= instr[6:4];
                        sh_q  <= SHAMT_W'(instr[3:0]);
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    alu_a     <= rs_val;
                    alu_b     <= rt_val;
                    alu_sel   <= op_q;
                    alu_shamt <= sh_q;
                    state     <= S_CAPT;
                end
                S_CAPT: begin
                    res_rd    <= rd_q;
                    res_valid <= 1'b1;
                    if (op_q == OP_ILLEGAL) begin
                        res_data <= '0;
                        res_err  <= 1'b1;
                    end else begin
                        res_data <= alu_result;
                        res_err  <= 1'b0;
                        if (rd_q != '0) begin
                            rf[rd_q] <= alu_result;
                        end
                    end
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a stub ALU and a
// transaction-level reference model of the register file and responses.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_sel;
    logic [3:0]  alu_shamt;
    logic [15:0] alu_result;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [2:0]  res_rd;
    logic        res_err;
    logic [15:0] op_count;

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_shamt  (alu_shamt),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_rd     (res_rd),
        .res_err    (res_err),
        .op_count   (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stub ALU; unused select returns a marker so error responses are distinguishable
    logic [15:0] alu_diff;
    assign alu_diff = alu_a - alu_b;
    always_comb begin
        case (alu_sel)
            3'd0:    alu_result = alu_a & alu_b;
            3'd1:    alu_result = alu_a | alu_b;
            3'd2:    alu_result = alu_a + alu_b;
            3'd3:    alu_result = alu_diff;
            3'd4:    alu_result = alu_a << alu_shamt;
            3'd5:    alu_result = alu_a >> alu_shamt;
            3'd6:    alu_result = {15'd0, alu_diff[15]};
            default: alu_result = 16'hDEAD;
        endcase
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected result from architectural rules, using plain integer arithmetic
    function automatic int model_op(input int op, input int a, input int b, input int sh);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return (a + b) % 65536;
            3: return (a - b + 65536) % 65536;
            4: return (a * (1 << sh)) % 65536;
            5: return a / (1 << sh);
            6: return (((a - b + 65536) % 65536) >= 32768) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    typedef struct {
        logic [15:0] data;
        logic [2:0]  rd;
        logic        err;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  sel;
        logic [3:0]  sh;
    } exp_t;

    exp_t        q[$];
    int          mregs[8];
    bit          busy    = 1'b0;
    bit          seen_v  = 1'b0;
    int          acc_cyc = 0;
    int          m_count = 0;
    int          resp_cnt = 0;
    logic [19:0] rlog[256];
    int          rr_mode = 0;

    // Single compare process: checks every cycle, then advances the model
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < 8; i++) mregs[i] = 0;
            busy    = 1'b0;
            seen_v  = 1'b0;
            m_count = 0;
        end else begin
            chk("instr_ready", instr_ready, (!busy && !cfg_we));
            chk("op_count", op_count, m_count % 65536);
            if (busy && !res_valid && (cyc - acc_cyc) >= 3)
                chk("res_valid_late", res_valid, 1'b1);
            if (res_valid) begin
                if (q.size() == 0) begin
                    chk("res_valid_spurious", res_valid, 1'b0);
                end else begin
                    chk("res_data", res_data, q[0].data);
                    chk("res_rd", res_rd, q[0].rd);
                    chk("res_err", res_err, q[0].err);
                    chk("alu_ports", {alu_a, alu_b, alu_sel, alu_shamt},
                        {q[0].a, q[0].b, q[0].sel, q[0].sh});
                    if (!seen_v) begin
                        chk("latency", cyc - acc_cyc, 3);
                        seen_v = 1'b1;
                    end
                end
            end
            if (cfg_we && !busy && cfg_addr != 3'd0)
                mregs[cfg_addr] = int'(cfg_wdata);
            if (instr_valid && instr_ready) begin
                exp_t e;
                int op, rd, rs, rt, sh, a, b;
                op = int'(instr[15:13]); rd = int'(instr[12:10]);
                rs = int'(instr[9:7]);   rt = int'(instr[6:4]);
                sh = int'(instr[3:0]);
                a  = (rs == 0) ? 0 : mregs[rs];
                b  = (rt == 0) ? 0 : mregs[rt];
                e.a   = 16'(a);
                e.b   = 16'(b);
                e.sel = 3'(op);
                e.sh  = 4'(sh);
                e.rd  = 3'(rd);
                e.err = (op == 7);
                e.data = (op == 7) ? 16'd0 : 16'(model_op(op, a, b, sh));
                if (op != 7 && rd != 0) mregs[rd] = int'(e.data);
                q.push_back(e);
                busy    = 1'b1;
                seen_v  = 1'b0;
                acc_cyc = cyc;
            end
            if (res_valid && res_ready && q.size() != 0) begin
                rlog[resp_cnt % 256] = {res_err, res_rd, res_data};
                void'(q.pop_front());
                busy = 1'b0;
                m_count++;
                resp_cnt++;
            end
        end
    end

    // Response-side back-pressure: 0 always ready, 1 random, 2 stalled
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'($urandom % 2);
                default: res_ready = 1'b0;
            endcase
        end
    end

    task automatic cfg_write(input logic [2:0] addr, input logic [15:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [3:0] sh);
        bit hs = 1'b0;
        int n  = 0;
        instr       = {op, rd, rs, rt, sh};
        instr_valid = 1'b1;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = instr_ready;
            @(posedge clk);
            #1;
            n++;
        end
        instr_valid = 1'b0;
        if (!hs) chk("issue_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) chk("resp_timeout", 1'b0, 1'b1);
    endtask

    task automatic reset_check(input string nm);
        chk(nm, {instr_ready, res_valid, res_data, res_rd, res_err,
                 alu_a, alu_b, alu_sel, alu_shamt, op_count}, '0);
    endtask

    initial begin
        int base;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        cfg_we      = 1'b0;
        cfg_addr    = '0;
        cfg_wdata   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_check("reset_state");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD r3 = r1 + r2, then read r3 back
        cfg_write(3'd1, 16'h00F0);
        cfg_write(3'd2, 16'h0F0F);
        base = resp_cnt;
        issue(3'd2, 3'd3, 3'd1, 3'd2, 4'd0);
        wait_idle();
        chk("add_result", rlog[base % 256], {1'b0, 3'd3, 16'h0FFF});
        issue(3'd1, 3'd7, 3'd3, 3'd0, 4'd0);
        wait_idle();
        chk("r3_readback", rlog[(base + 1) % 256], {1'b0, 3'd7, 16'h0FFF});

        // Back-to-back SUB and SLT
        base = resp_cnt;
        issue(3'd3, 3'd4, 3'd2, 3'd1, 4'd0);
        issue(3'd6, 3'd5, 3'd1, 3'd2, 4'd0);
        wait_idle();
        chk("sub_result", rlog[base % 256], {1'b0, 3'd4, 16'h0E1F});
        chk("slt_result", rlog[(base + 1) % 256], {1'b0, 3'd5, 16'h0001});

        // SHL with response stalled for five cycles
        rr_mode = 2;
        base = resp_cnt;
        issue(3'd4, 3'd7, 3'd1, 3'd0, 4'd4);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("shl_hold_valid", res_valid, 1'b1);
        end
        chk("shl_shamt", alu_shamt, 4'd4);
        rr_mode = 0;
        wait_idle();
        chk("shl_result", rlog[base % 256], {1'b0, 3'd7, 16'h0F00});

        // Illegal op leaves destination untouched
        cfg_write(3'd6, 16'h1234);
        base = resp_cnt;
        issue(3'd7, 3'd6, 3'd1, 3'd2, 4'd0);
        wait_idle();
        chk("illegal_resp", rlog[base % 256], {1'b1, 3'd6, 16'h0000});
        issue(3'd1, 3'd2, 3'd6, 3'd0, 4'd0);
        wait_idle();
        chk("r6_unchanged", rlog[(base + 1) % 256], {1'b0, 3'd2, 16'h1234});
        chk("op_count_7", op_count, 16'd7);

        // Preload collides with an offered instruction
        cfg_we      = 1'b1;
        cfg_addr    = 3'd5;
        cfg_wdata   = 16'hAAAA;
        instr       = {3'd1, 3'd1, 3'd5, 3'd0, 4'd0};
        instr_valid = 1'b1;
        @(negedge clk);
        chk("cfg_priority_ready", instr_ready, 1'b0);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        base = resp_cnt;
        issue(3'd1, 3'd1, 3'd5, 3'd0, 4'd0);
        wait_idle();
        chk("cfg_then_instr", rlog[base % 256], {1'b0, 3'd1, 16'hAAAA});

        // Reset asserted while in CAPT
        issue(3'd2, 3'd3, 3'd1, 3'd2, 4'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        reset_check("midop_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = resp_cnt;
        issue(3'd1, 3'd2, 3'd3, 3'd0, 4'd0);
        cfg_write(3'd0, 16'h5555);
        wait_idle();
        issue(3'd2, 3'd1, 3'd0, 3'd0, 4'd0);
        wait_idle();
        chk("rf_cleared", rlog[base % 256], {1'b0, 3'd2, 16'h0000});
        chk("r0_reads_zero", rlog[(base + 1) % 256], {1'b0, 3'd1, 16'h0000});

        // Randomized traffic with random back-pressure and stray preloads
        rr_mode = 1;
        for (int k = 0; k < 150; k++) begin
            if ($urandom % 3 == 0)
                cfg_write(3'($urandom % 8), 16'($urandom));
            issue(3'($urandom % 8), 3'($urandom % 8), 3'($urandom % 8),
                  3'($urandom % 8), 4'($urandom % 16));
        end
        rr_mode = 0;
        wait_idle();
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
